// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between decode, instruction memory and the fetch controller.
// The controller connects through the slave modport; the master side drives decode and imem inputs.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_SEL_WIDTH
`define PC_SEL_WIDTH 3
`endif
`ifndef PC_SEL_PC4
`define PC_SEL_PC4 3'd0
`endif
`ifndef PC_SEL_BRANCH
`define PC_SEL_BRANCH 3'd1
`endif
`ifndef PC_SEL_JAL
`define PC_SEL_JAL 3'd2
`endif
`ifndef PC_SEL_JALR
`define PC_SEL_JALR 3'd3
`endif

interface fetch_ctrl_if;
    logic [`PC_SEL_WIDTH-1:0] pc_sel;
    logic                     stall_decode;
    logic                     imem_ack;
    logic                     imem_req;
    logic                     stall_if;
    logic                     flush_if;
    logic                     err_timeout;
    logic [`XLEN-1:0]         fetch_count;

    modport master (
        output pc_sel, stall_decode, imem_ack,
        input  imem_req, stall_if, flush_if, err_timeout, fetch_count
    );

    modport slave (
        input  pc_sel, stall_decode, imem_ack,
        output imem_req, stall_if, flush_if, err_timeout, fetch_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences imem requests, stalls/flushes IF/ID,
// drops stale responses after a redirect and flags requests that wait too long.
module fetch_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    fetch_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] DROP = 2'd3;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [1:0]       state_q, state_d;
    logic [7:0]       waitCnt_q, waitCnt_d;
    logic             err_q, err_d;
    logic [`XLEN-1:0] fetchCount_q, fetchCount_d;

    logic redirect;
    logic accept;
    logic imemReq;
    logic stallIf;
    logic flushIf;
    logic waiting;
    logic enterWait;

    always_comb begin
        redirect = (bus.pc_sel == `PC_SEL_BRANCH) ||
                   (bus.pc_sel == `PC_SEL_JAL)    ||
                   (bus.pc_sel == `PC_SEL_JALR);
    end

    // Redirect is tested first in every state so it always wins over ack and stall.
    always_comb begin
        state_d = state_q;
        imemReq = 1'b0;
        stallIf = 1'b1;
        flushIf = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                flushIf = 1'b1;
                state_d = REQ;
            end
            REQ: begin
                imemReq = 1'b1;
                if (redirect) begin
                    flushIf = 1'b1;
                    stallIf = 1'b0;
                    if (!bus.imem_ack) begin
                        state_d = DROP;
                    end
                end else if (bus.imem_ack) begin
                    if (bus.stall_decode) begin
                        state_d = HOLD;
                    end else begin
                        stallIf = 1'b0;
                        accept  = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    flushIf = 1'b1;
                    stallIf = 1'b0;
                    state_d = REQ;
                end else if (!bus.stall_decode) begin
                    stallIf = 1'b0;
                    accept  = 1'b1;
                    state_d = REQ;
                end
            end
            DROP: begin
                flushIf = 1'b1;
                if (redirect) begin
                    stallIf = 1'b0;
                end else if (bus.imem_ack) begin
                    state_d = REQ;
                end
            end
            default: begin
                flushIf = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // The wait counter only measures time with a request on the bus (REQ or DROP).
    always_comb begin
        waiting   = (state_q == REQ) || (state_q == DROP);
        enterWait = (state_d != state_q) && ((state_d == REQ) || (state_d == DROP));
        waitCnt_d = waitCnt_q;
        if (enterWait || (waiting && bus.imem_ack)) begin
            waitCnt_d = 8'd0;
        end else if (waiting && (waitCnt_q < TIMEOUT_C)) begin
            waitCnt_d = waitCnt_q + 8'd1;
        end
        err_d        = err_q | (waitCnt_d == TIMEOUT_C);
        fetchCount_d = accept ? fetchCount_q + `XLEN'(1) : fetchCount_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            waitCnt_q    <= 8'd0;
            err_q        <= 1'b0;
            fetchCount_q <= '0;
        end else begin
            state_q      <= state_d;
            waitCnt_q    <= waitCnt_d;
            err_q        <= err_d;
            fetchCount_q <= fetchCount_d;
        end
    end

    assign bus.imem_req    = imemReq;
    assign bus.stall_if    = stallIf;
    assign bus.flush_if    = flushIf;
    assign bus.err_timeout = err_q;
    assign bus.fetch_count = fetchCount_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a request/response level model predicts each cycle's
// outputs, a negedge monitor compares them, and a few directed scenarios pin exact values.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_SEL_WIDTH
`define PC_SEL_WIDTH 3
`endif
`ifndef PC_SEL_PC4
`define PC_SEL_PC4 3'd0
`endif
`ifndef PC_SEL_BRANCH
`define PC_SEL_BRANCH 3'd1
`endif
`ifndef PC_SEL_JAL
`define PC_SEL_JAL 3'd2
`endif
`ifndef PC_SEL_JALR
`define PC_SEL_JALR 3'd3
`endif

module tb_fetch_ctrl;

    localparam int TO = 4;

    typedef struct packed {
        logic             req;
        logic             stall;
        logic             flush;
        logic             err;
        logic [`XLEN-1:0] count;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fetch_ctrl_if bus();

    fetch_ctrl #(.TIMEOUT(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t expQ[$];
    exp_t monExp;

    // Model state: what the fetch unit knows about requests, not how the RTL encodes it.
    bit               mdlWarmup;
    bit               mdlFresh;
    bit               mdlStale;
    bit               mdlHeld;
    int               mdlWait;
    bit               mdlErr;
    logic [`XLEN-1:0] mdlCount;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic waitTick();
        if (mdlWait < TO) mdlWait++;
        if (mdlWait >= TO) mdlErr = 1'b1;
    endtask

    task automatic modelStep(input bit rstLow, input logic [2:0] sel, input bit sd, input bit ack);
        exp_t e;
        bit redir;
        redir = (sel == `PC_SEL_BRANCH) || (sel == `PC_SEL_JAL) || (sel == `PC_SEL_JALR);
        if (rstLow) begin
            e = '{req: 1'b0, stall: 1'b1, flush: 1'b1, err: 1'b0, count: '0};
            mdlWarmup = 1'b1; mdlFresh = 1'b0; mdlStale = 1'b0; mdlHeld = 1'b0;
            mdlWait = 0; mdlErr = 1'b0; mdlCount = '0;
            expQ.push_back(e);
            return;
        end
        e = '{req: 1'b0, stall: 1'b1, flush: 1'b0, err: mdlErr, count: mdlCount};
        if (mdlWarmup) begin
            e.flush = 1'b1;
            mdlWarmup = 1'b0; mdlFresh = 1'b1; mdlWait = 0;
        end else if (mdlHeld) begin
            if (redir) begin
                e.flush = 1'b1; e.stall = 1'b0;
                mdlHeld = 1'b0; mdlFresh = 1'b1; mdlWait = 0;
            end else if (!sd) begin
                e.stall = 1'b0;
                mdlCount = mdlCount + 1'b1;
                mdlHeld = 1'b0; mdlFresh = 1'b1; mdlWait = 0;
            end
        end else if (mdlStale) begin
            e.flush = 1'b1;
            if (redir) begin
                e.stall = 1'b0;
                if (ack) mdlWait = 0; else waitTick();
            end else if (ack) begin
                mdlStale = 1'b0; mdlFresh = 1'b1; mdlWait = 0;
            end else begin
                waitTick();
            end
        end else begin
            e.req = 1'b1;
            if (redir) begin
                e.flush = 1'b1; e.stall = 1'b0;
                if (!ack) begin
                    mdlFresh = 1'b0; mdlStale = 1'b1;
                end
                mdlWait = 0;
            end else if (ack) begin
                mdlWait = 0;
                if (sd) begin
                    mdlFresh = 1'b0; mdlHeld = 1'b1;
                end else begin
                    e.stall = 1'b0;
                    mdlCount = mdlCount + 1'b1;
                end
            end else begin
                waitTick();
            end
        end
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input bit rstLow, input logic [2:0] sel, input bit sd, input bit ack);
        @(posedge clk);
        #1;
        rst_n            = !rstLow;
        bus.pc_sel       = sel;
        bus.stall_decode = sd;
        bus.imem_ack     = ack;
        modelStep(rstLow, sel, sd, ack);
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkOutput("imem_req",    32'(bus.imem_req),    32'(monExp.req));
            checkOutput("stall_if",    32'(bus.stall_if),    32'(monExp.stall));
            checkOutput("flush_if",    32'(bus.flush_if),    32'(monExp.flush));
            checkOutput("err_timeout", 32'(bus.err_timeout), 32'(monExp.err));
            checkOutput("fetch_count", 32'(bus.fetch_count), 32'(monExp.count));
        end
    end

    initial begin
        logic [2:0] sel;
        int r;
        bus.pc_sel = `PC_SEL_PC4;
        bus.stall_decode = 1'b0;
        bus.imem_ack = 1'b0;

        applyStimulus(1'b1, `PC_SEL_PC4, 1'b0, 1'b0);
        applyStimulus(1'b1, `PC_SEL_PC4, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rst_req",   32'(bus.imem_req), 32'd0);
        checkOutput("rst_stall", 32'(bus.stall_if), 32'd1);
        checkOutput("rst_flush", 32'(bus.flush_if), 32'd1);
        checkOutput("rst_count", bus.fetch_count,   32'd0);

        // Back-to-back accepted fetches after reset release.
        applyStimulus(1'b0, `PC_SEL_PC4, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("first_cycle_idle_req", 32'(bus.imem_req), 32'd0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, `PC_SEL_PC4, 1'b0, 1'b1);
        applyStimulus(1'b0, `PC_SEL_PC4, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("burst_count", bus.fetch_count, 32'd9);
        checkOutput("burst_req",   32'(bus.imem_req), 32'd1);

        // Ack under decode stall, held three cycles, then released.
        applyStimulus(1'b0, `PC_SEL_PC4, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, `PC_SEL_PC4, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("hold_req",   32'(bus.imem_req), 32'd0);
        checkOutput("hold_stall", 32'(bus.stall_if), 32'd1);
        applyStimulus(1'b0, `PC_SEL_PC4, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("hold_release_stall", 32'(bus.stall_if), 32'd0);
        applyStimulus(1'b0, `PC_SEL_PC4, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("hold_count", bus.fetch_count, 32'd10);

        // Redirect mid-request; the late ack is dropped.
        applyStimulus(1'b0, `PC_SEL_JAL, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("redir_flush", 32'(bus.flush_if), 32'd1);
        checkOutput("redir_stall", 32'(bus.stall_if), 32'd0);
        applyStimulus(1'b0, `PC_SEL_PC4, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("drop_req", 32'(bus.imem_req), 32'd0);
        applyStimulus(1'b0, `PC_SEL_PC4, 1'b0, 1'b1);
        applyStimulus(1'b0, `PC_SEL_PC4, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("drop_resume_req", 32'(bus.imem_req), 32'd1);
        checkOutput("drop_count",      bus.fetch_count,   32'd10);

        // Redirect coincident with ack.
        applyStimulus(1'b0, `PC_SEL_JALR, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("redir_ack_req",   32'(bus.imem_req), 32'd1);
        checkOutput("redir_ack_flush", 32'(bus.flush_if), 32'd1);
        applyStimulus(1'b0, `PC_SEL_PC4, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("redir_ack_count", bus.fetch_count, 32'd10);

        // Timeout: that cycle was the first wait; three more reach TIMEOUT.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, `PC_SEL_PC4, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("err_before_limit", 32'(bus.err_timeout), 32'd0);
        applyStimulus(1'b0, `PC_SEL_PC4, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("err_at_limit", 32'(bus.err_timeout), 32'd1);
        applyStimulus(1'b0, `PC_SEL_PC4, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("err_sticky", 32'(bus.err_timeout), 32'd1);
        applyStimulus(1'b1, `PC_SEL_PC4, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("err_cleared", 32'(bus.err_timeout), 32'd0);

        // Counter wrap from all-ones.
        applyStimulus(1'b0, `PC_SEL_PC4, 1'b0, 1'b0);
        applyStimulus(1'b0, `PC_SEL_PC4, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        force dut.fetchCount_q = '1;
        mdlCount = '1;
        #1;
        release dut.fetchCount_q;
        applyStimulus(1'b0, `PC_SEL_PC4, 1'b0, 1'b1);
        applyStimulus(1'b0, `PC_SEL_PC4, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("wrap_count", bus.fetch_count, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)     sel = 3'($urandom_range(1, 3));
            else if (r < 6) sel = `PC_SEL_PC4;
            else            sel = 3'($urandom_range(4, 7));
            applyStimulus($urandom_range(0, 149) == 0, sel,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        end

        @(negedge clk);
        #1;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles an imem request may wait for imem_ack before err_timeout sets (legal range 1..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 pc_sel  input  `PC_SEL_WIDTH  next-pc select from decode; redirect = value equals `PC_SEL_BRANCH, `PC_SEL_JAL or `PC_SEL_JALR.
REQ-005 stall_decode  input  1  downstream hazard stall; decode cannot accept an instruction this cycle.
REQ-006 imem_ack  input  1  one-cycle pulse; instr_imem valid for the current pc this cycle.
REQ-007 imem_req  output  1  fetch request to instruction memory; imem samples pc_imem while high.
REQ-008 stall_if  output  1  fetch stage holds pc and IF/ID registers when high.
REQ-009 flush_if  output  1  fetch stage writes a bubble into IF/ID when high.
REQ-010 err_timeout  output  1  sticky; a request exceeded TIMEOUT cycles.
REQ-011 fetch_count  output  `XLEN  count of instructions handed to decode.

Function
REQ-012 States: IDLE, REQ (request outstanding), HOLD (response received, decode stalled), DROP (stale request outstanding after redirect).
REQ-013 redirect = pc_sel decodes as redirect; redirect has priority over stall_decode and imem_ack in every state.
REQ-014 IDLE: imem_req=0, stall_if=1, flush_if=1; next state REQ unconditionally.
REQ-015 REQ: imem_req=1. No ack, no redirect: stall_if=1, flush_if=0, stay.
REQ-016 REQ, ack, no redirect, stall_decode=0: stall_if=0 for that cycle (fetch accepts), fetch_count+1, stay REQ; the next request starts the following cycle.
REQ-017 REQ, ack, no redirect, stall_decode=1: stall_if=1, go HOLD.
REQ-018 HOLD: imem_req=0; the memory keeps instr_imem stable. stall_decode=1: stall_if=1, stay. stall_decode=0: stall_if=0, fetch_count+1, go REQ.
REQ-019 Redirect in REQ without ack: flush_if=1, stall_if=0 for one cycle (pc loads target), go DROP.
REQ-020 Redirect in REQ with ack: response discarded, flush_if=1, stall_if=0, fetch_count unchanged, stay REQ.
REQ-021 Redirect in HOLD: held instruction discarded, flush_if=1, stall_if=0, go REQ.
REQ-022 DROP: imem_req=0, stall_if=1, flush_if=1; on imem_ack discard the response and go REQ. A redirect in DROP gives flush_if=1, stall_if=0 for one cycle and stays DROP.
REQ-023 flush_if=0 in every case not listed above; stall_if and flush_if are registered-state combinational outputs with no additional latency.
REQ-024 Wait counter (8 bits): clears on entry to REQ or DROP and on every ack. It increments each cycle spent in REQ or DROP without an ack and saturates at TIMEOUT.
REQ-025 When the wait counter reaches TIMEOUT, err_timeout sets and holds until reset; state behaviour is unchanged.
REQ-026 fetch_count wraps from 2^XLEN-1 to 0; it never increments on a flushed or discarded response.
REQ-027 An imem_ack in IDLE or HOLD is ignored (protocol violation; no state change).

Reset
REQ-028 rst_n low: state=IDLE, imem_req=0, stall_if=1, flush_if=1, err_timeout=0, fetch_count=0, wait counter=0. All take effect immediately, regardless of clk.
REQ-029 Reset asserted mid-request: the outstanding request is abandoned. After release, the first cycle is IDLE, then REQ.

Verification
REQ-030 Release reset; ack on every REQ cycle, 10 cycles -> imem_req=1 from the 2nd cycle, stall_if=0 on each ack cycle, fetch_count=9.
REQ-031 Ack with stall_decode=1 for 3 cycles -> HOLD for 3 cycles with imem_req=0, stall_if=1; stall_if=0 on release; fetch_count+1 exactly once.
REQ-032 Redirect (pc_sel=`PC_SEL_JAL) 2 cycles into a request, ack 2 cycles later -> flush_if=1/stall_if=0 one cycle, then DROP with imem_req=0. The ack is discarded, REQ resumes, fetch_count unchanged.
REQ-033 Redirect coincident with ack -> flush_if=1, stall_if=0, fetch_count unchanged, imem_req stays 1.
REQ-034 TIMEOUT=4, no ack -> err_timeout=1 after the 4th waiting cycle and remains 1 after a later ack; cleared only by rst_n=0.
REQ-035 fetch_count preloaded to 2^XLEN-1 via force, one accepted fetch -> fetch_count=0.
